// File: rtl/sg_uart_rx_mon.sv
// sg_uart_rx_mon: serial receive monitor for 8N1 frames at a programmable
// bit period. Received bytes go into a small FIFO that is popped with a
// valid/ready handshake. The block also reports framing errors, sticky
// overrun and a count of good bytes received.
module sg_uart_rx_mon #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RXD,
  input  logic [19:0]      BAUDDIV,
  output logic [7:0]       RX_DATA,
  output logic             RX_VALID,
  input  logic             RX_READY,
  output logic             FRAME_ERR,
  output logic             OVERRUN,
  input  logic             CLR_STATUS,
  output logic [CNT_W-1:0] BYTE_CNT,
  output logic             BUSY
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Synchroniser and edge detect
  logic sync1_q;
  logic rxs_q;
  logic rxs_prev_q;

  // Receiver FSM
  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        frame_err_q, frame_err_d;
  logic        push;
  logic [19:0] div_clamped;

  // FIFO and status
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             ovr_evt;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  assign div_clamped = (BAUDDIV < 20'd16) ? 20'd16 : BAUDDIV;

  // Two-flop synchroniser on the asynchronous line, plus one delay for edge detect
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= RXD;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Receiver state register and datapath registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= 20'd16;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Receiver next-state: counters hold (cycles to wait - 1), so a bit is
  // sampled exactly div_q cycles after the previous sample.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          div_d   = div_clamped;
          cnt_d   = (div_clamped >> 1) - 20'd1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 20'd1;
        end else if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = div_q - 20'd1;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 20'd1;
        end else begin
          shift_d[idx_q] = rxs_q;
          cnt_d          = div_q - 20'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 20'd1;
        end else if (rxs_q) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign BUSY      = (state_q != S_IDLE);
  assign FRAME_ERR = frame_err_q;

  // FIFO control: a pop in the same cycle frees the slot a full-FIFO push needs
  assign pop      = RX_VALID && RX_READY;
  assign full     = (count_q == DEPTH_C);
  assign push_ok  = push && (!full || pop);
  assign ovr_evt  = push && full && !pop;
  assign RX_VALID = (count_q != '0);
  assign RX_DATA  = RX_VALID ? mem_q[rd_ptr_q] : '0;

  // FIFO pointer/occupancy and status next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    byte_cnt_d = byte_cnt_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - (AW + 1)'(1);
    end
    if (ovr_evt) begin
      overrun_d = 1'b1;
    end else if (CLR_STATUS) begin
      overrun_d = 1'b0;
    end
    if (push_ok) begin
      byte_cnt_d = (CLR_STATUS ? '0 : byte_cnt_q) + CNT_W'(1);
    end else if (CLR_STATUS) begin
      byte_cnt_d = '0;
    end
  end

  // FIFO storage, pointers and status registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign OVERRUN  = overrun_q;
  assign BYTE_CNT = byte_cnt_q;

endmodule

// File: doc/sg_uart_rx_mon.md
Name: sg_uart_rx_mon

Overview:
Serial receive monitor that sits directly downstream of the UART transmitter in the UART test environment, decoding its TXD line. Decodes CMSDK-format frames (1 start, 8 data LSB-first, 1 stop, no parity) at a programmable bit period. Buffers received bytes in a small FIFO with valid/ready pop handshake. Reports framing errors, overrun and a received-byte count so the bench can check what the transmitter actually sent.

Parameters:
FIFO_DEPTH, 4, receive FIFO entries; power of 2, minimum 2
CNT_W, 16, width of BYTE_CNT

Ports:
CLK  input  1  clock; all logic on rising edge
RESET  input  1  asynchronous, active-high reset
RXD  input  1  serial line (connect to transmitter TXD); asynchronous, idle high
BAUDDIV  input  20  bit period in CLK cycles; values below 16 are treated as 16
RX_DATA  output  8  FIFO head byte; valid only when RX_VALID=1
RX_VALID  output  1  FIFO not empty
RX_READY  input  1  pop request; a pop occurs when RX_VALID && RX_READY
FRAME_ERR  output  1  one-cycle pulse when a stop bit is sampled low
OVERRUN  output  1  sticky: byte dropped because FIFO was full
CLR_STATUS  input  1  synchronous clear of OVERRUN and BYTE_CNT
BYTE_CNT  output  CNT_W  count of good bytes pushed; wraps at 2^CNT_W
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, RESET=1): state IDLE, synchroniser flops =1, FIFO empty, RX_VALID=0, RX_DATA=0, FRAME_ERR=0, OVERRUN=0, BYTE_CNT=0, BUSY=0. RESET mid-frame abandons the frame; no partial byte is pushed.
- RXD passes through a 2-flop synchroniser (reset value 1); the synchronised value is rxs. Edge detect compares rxs with its previous value.
- BAUDDIV is latched into div_q on leaving IDLE; changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on rxs falling edge load counter with div_q>>1, go START.
- START: counter decrements; at 0 sample rxs. rxs=1 -> glitch, back to IDLE, nothing reported. rxs=0 -> load div_q, bit index=0, go DATA.
- DATA: at counter 0 shift rxs into bit[index] (LSB first), reload div_q; after index 7 go STOP.
- STOP: at counter 0 sample rxs. 1 -> push byte, go IDLE the same cycle, so a back-to-back start edge half a bit later is caught. 0 -> FRAME_ERR pulse for one cycle, byte discarded, BYTE_CNT unchanged, go WAIT_HIGH.
- WAIT_HIGH: remain until rxs=1, then IDLE. This covers break conditions; no additional frames are detected while the line is low.
- Sample point: each bit is sampled at its midpoint, div_q>>1 cycles into the start bit plus k*div_q thereafter.
- FIFO: circular buffer with read/write pointers and an occupancy count. RX_DATA is the registered head, combinational from storage. A push is visible as RX_VALID the cycle after the stop sample.
- Push into a full FIFO: if a pop occurs in the same cycle, the push succeeds. Otherwise the new byte is dropped, OVERRUN is set and BYTE_CNT is not incremented. Existing FIFO contents are unchanged.
- Pop from an empty FIFO is ignored.
- Simultaneous push and pop when not full or empty: occupancy is unchanged and both pointers advance.
- BYTE_CNT increments on each successful push and wraps to 0 after all ones.
- CLR_STATUS clears OVERRUN and BYTE_CNT. If CLR_STATUS and a successful push happen in the same cycle, BYTE_CNT=1 (the increment wins over the clear base). If CLR_STATUS coincides with an overrun event, OVERRUN=1 (set wins).
- Latency from RXD start falling edge to RX_VALID: 2 + (div_q>>1) + 9*div_q + 1 cycles, ±1 for edge alignment. For BAUDDIV=16 this is 155 cycles.

Test Plan:
- BAUDDIV=16, drive frame 0x55, RX_READY=0 -> RX_VALID rises 155±1 cycles after the start edge; RX_DATA=0x55, BYTE_CNT=1, FRAME_ERR never pulses.
- BAUDDIV=16, back-to-back frames 0xA3, 0x0F, 0xFF, 0x00 with no idle gap, RX_READY=0 -> FIFO holds 4 entries. A 5th frame 0x7E sets OVERRUN=1, BYTE_CNT=4. Popping returns A3, 0F, FF, 00 in order, and RX_VALID=0 after the 4th pop.
- Frame 0x3C with stop bit driven 0, then line held low for 40 bit periods -> single FRAME_ERR pulse, BYTE_CNT unchanged, BUSY=1 until the line returns high. Next frame 0x81 is received correctly.
- Low glitch on RXD of 3 cycles with BAUDDIV=32 -> back to IDLE, nothing pushed, no FRAME_ERR.
- BAUDDIV=8 (clamped to 16) vs BAUDDIV=16 with the same bit-period stimulus -> identical received bytes. Changing BAUDDIV from 16 to 64 mid-frame does not corrupt the current byte.
- RESET asserted at data bit 4 of frame 0xC5 -> all outputs return to reset values immediately. The following clean frame 0x5A is received with BYTE_CNT=1. CLR_STATUS coincident with a push gives BYTE_CNT=1.
